alu_hs: RTL and testbench
=========================

Name: alu_hs

Overview:
- Second-generation parametrised system ALU with a valid/ready input handshake, registered result and flags, and a multi-cycle iterative divider.
- Sits between the register-file/control FSM and the result path of the multi-clock system, in the same domain as the control unit.
- Single-cycle ops complete in 1 cycle; division takes DATA_WIDTH cycles, during which the input side stalls.

Parameters:
- DATA_WIDTH, 8, operand width W. Legal values: 2 and above.
- ALU_FUN_WIDTH, 4, opcode width. Only codes 0..14 are defined; every other value is illegal.

Ports:
- i_CLK  input  1  clock
- i_RST  input  1  reset, asynchronous, active-low
- i_A  input  DATA_WIDTH  operand A (unsigned)
- i_B  input  DATA_WIDTH  operand B (unsigned)
- i_ALU_FUN  input  ALU_FUN_WIDTH  opcode
- i_Valid  input  1  request valid
- o_Ready  output  1  block can accept a request
- o_ALU_OUT  output  2*DATA_WIDTH  result
- o_OUT_Valid  output  1  one-cycle result strobe
- o_Zero  output  1  result == 0
- o_Carry  output  1  carry/borrow/overflow flag
- o_Err  output  1  divide-by-zero or illegal opcode

Behaviour:
- Reset state: o_ALU_OUT=0, o_OUT_Valid=0, o_Zero=0, o_Carry=0, o_Err=0; state IDLE; o_Ready=1 once reset is released.
- Reset is honoured at any time. Reset during DIV aborts the operation with no valid pulse.
- Accept: a request is taken on a rising edge where i_Valid && o_Ready. o_Ready = (state==IDLE), driven combinationally from the state register.
- Opcodes (result width 2W; results are zero-extended unless noted):
  - 0 ADD: A+B.
  - 1 SUB: A-B modulo 2^(2W).
  - 2 MUL: A*B.
  - 3 DIV: {remainder, quotient}, remainder in the upper W bits.
  - 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR: bitwise, W bits, zero-extended.
  - 10 A==B, 11 A>B, 12 A<B: result 1 or 0.
  - 13 SHL: A<<1, W+1 bits.
  - 14 SHR: A>>1.
  - Illegal codes: result 0, o_Err=1.
- o_Carry:
  - ADD: bit W of the sum.
  - SUB: borrow (A<B).
  - MUL: upper W bits nonzero.
  - SHL: A[W-1].
  - All other ops: 0.
- o_Zero = (o_ALU_OUT==0), registered together with the result.
- Single-cycle ops: result, flags and o_OUT_Valid are registered on the accepting edge. Latency is 1; one op per cycle is sustainable.
- Output registers hold their value until the next completion. o_OUT_Valid is high for exactly one cycle per request. There is no output back-pressure.
- DIV with B==0: completes as a single-cycle op with result 0, o_Err=1, and no DIV state.
- DIV with B!=0:
  - Accepting edge latches the operands and enters DIV with the iteration counter at 0.
  - Each edge in DIV performs one restoring shift-subtract step.
  - On the edge performing step W-1, result, flags and o_OUT_Valid are registered and the state returns to IDLE.
  - Valid therefore appears W cycles after acceptance. o_Ready is low for W cycles.
  - i_Valid asserted while busy is ignored; the requester must hold it.
- o_Err is cleared on every successful completion.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined: iterative divider and DIV state present, as described above.
- Undefined: no divider logic. Opcode 3 is treated as illegal (1-cycle, result 0, o_Err=1). o_Ready is constant 1 outside reset.

Test Plan (W=8):
- ADD 200,100 -> next cycle o_ALU_OUT=16'h012C, o_Carry=1, o_Zero=0, single-cycle o_OUT_Valid.
- SUB 3,5 -> 16'hFFFE, o_Carry=1; MUL 255,255 -> 16'hFE01, o_Carry=1.
- DIV 200,7 -> o_Ready low 8 cycles, then o_ALU_OUT=16'h041C with o_OUT_Valid. A second request held on i_Valid is accepted only once o_Ready returns to 1. Without ALU_DIV_EN: result 0, o_Err=1 after 1 cycle.
- DIV 5,0 -> 1 cycle, o_ALU_OUT=0, o_Zero=1, o_Err=1. A following ADD 1,1 -> 16'h0002, o_Err=0.
- Back-to-back, one op per cycle: XOR A5,0F -> 16'h00AA; EQ 3,3 -> 16'h0001; SHR 01 -> 0 with o_Zero=1; opcode 15 -> 0 with o_Err=1; four consecutive valid strobes.
- Assert i_RST at DIV step 3 of 200/7 -> all outputs 0 immediately. After release o_Ready=1 and no o_OUT_Valid pulse occurs.

Source files
------------

// File: rtl/alu_hs.sv
// alu_hs: parametrised system ALU with a valid/ready input handshake,
// registered result/flags and an optional multi-cycle restoring divider.
// Optional feature macro: ALU_DIV_EN (defined = iterative divider present;
// undefined = opcode 3 is illegal and o_Ready is always 1).
//
// Handshake: a request is accepted on a rising i_CLK edge where
// i_Valid && o_Ready. o_Ready is combinational from the state register only.
// Results have no back-pressure: o_OUT_Valid is a one-cycle strobe and the
// result/flag registers hold until the next completion.
// The FSM state is visible on the internal signal dbg_state.
module alu_hs #(
  parameter int DATA_WIDTH    = 8,
  parameter int ALU_FUN_WIDTH = 4
) (
  input  logic                      i_CLK,
  input  logic                      i_RST,
  input  logic [DATA_WIDTH-1:0]     i_A,
  input  logic [DATA_WIDTH-1:0]     i_B,
  input  logic [ALU_FUN_WIDTH-1:0]  i_ALU_FUN,
  input  logic                      i_Valid,
  output logic                      o_Ready,
  output logic [2*DATA_WIDTH-1:0]   o_ALU_OUT,
  output logic                      o_OUT_Valid,
  output logic                      o_Zero,
  output logic                      o_Carry,
  output logic                      o_Err
);

  localparam int W = DATA_WIDTH;

  localparam logic [ALU_FUN_WIDTH-1:0] OP_ADD  = ALU_FUN_WIDTH'(0);
  localparam logic [ALU_FUN_WIDTH-1:0] OP_SUB  = ALU_FUN_WIDTH'(1);
  localparam logic [ALU_FUN_WIDTH-1:0] OP_MUL  = ALU_FUN_WIDTH'(2);
  localparam logic [ALU_FUN_WIDTH-1:0] OP_DIV  = ALU_FUN_WIDTH'(3);
  localparam logic [ALU_FUN_WIDTH-1:0] OP_AND  = ALU_FUN_WIDTH'(4);
  localparam logic [ALU_FUN_WIDTH-1:0] OP_OR   = ALU_FUN_WIDTH'(5);
  localparam logic [ALU_FUN_WIDTH-1:0] OP_NAND = ALU_FUN_WIDTH'(6);
  localparam logic [ALU_FUN_WIDTH-1:0] OP_NOR  = ALU_FUN_WIDTH'(7);
  localparam logic [ALU_FUN_WIDTH-1:0] OP_XOR  = ALU_FUN_WIDTH'(8);
  localparam logic [ALU_FUN_WIDTH-1:0] OP_XNOR = ALU_FUN_WIDTH'(9);
  localparam logic [ALU_FUN_WIDTH-1:0] OP_EQ   = ALU_FUN_WIDTH'(10);
  localparam logic [ALU_FUN_WIDTH-1:0] OP_GT   = ALU_FUN_WIDTH'(11);
  localparam logic [ALU_FUN_WIDTH-1:0] OP_LT   = ALU_FUN_WIDTH'(12);
  localparam logic [ALU_FUN_WIDTH-1:0] OP_SHL  = ALU_FUN_WIDTH'(13);
  localparam logic [ALU_FUN_WIDTH-1:0] OP_SHR  = ALU_FUN_WIDTH'(14);

  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;
  logic [2*W-1:0] res_c;
  logic           carry_c;
  logic           err_c;
  logic           start_div;
  logic           accept;
  logic           div_done;
  logic [2*W-1:0] div_res;

  assign a_ext  = {{W{1'b0}}, i_A};
  assign b_ext  = {{W{1'b0}}, i_B};
  assign accept = i_Valid && o_Ready;

  // Single-cycle result, flags and the decision to start a division.
  always_comb begin
    res_c     = '0;
    carry_c   = 1'b0;
    err_c     = 1'b0;
    start_div = 1'b0;
    case (i_ALU_FUN)
      OP_ADD: begin
        res_c   = a_ext + b_ext;
        carry_c = res_c[W];
      end
      OP_SUB: begin
        res_c   = a_ext - b_ext;
        carry_c = (i_A < i_B);
      end
      OP_MUL: begin
        res_c   = a_ext * b_ext;
        carry_c = |res_c[2*W-1:W];
      end
      OP_DIV: begin
`ifdef ALU_DIV_EN
        // Divide by zero finishes immediately as an error, no DIV state.
        if (i_B == '0) err_c = 1'b1;
        else           start_div = 1'b1;
`else
        err_c = 1'b1;
`endif
      end
      OP_AND:  res_c = {{W{1'b0}}, i_A & i_B};
      OP_OR:   res_c = {{W{1'b0}}, i_A | i_B};
      OP_NAND: res_c = {{W{1'b0}}, ~(i_A & i_B)};
      OP_NOR:  res_c = {{W{1'b0}}, ~(i_A | i_B)};
      OP_XOR:  res_c = {{W{1'b0}}, i_A ^ i_B};
      OP_XNOR: res_c = {{W{1'b0}}, ~(i_A ^ i_B)};
      OP_EQ:   res_c = {{(2*W-1){1'b0}}, (i_A == i_B)};
      OP_GT:   res_c = {{(2*W-1){1'b0}}, (i_A > i_B)};
      OP_LT:   res_c = {{(2*W-1){1'b0}}, (i_A < i_B)};
      OP_SHL: begin
        res_c   = {{(W-1){1'b0}}, i_A, 1'b0};
        carry_c = i_A[W-1];
      end
      OP_SHR:  res_c = {{(W+1){1'b0}}, i_A[W-1:1]};
      default: err_c = 1'b1;
    endcase
  end

`ifdef ALU_DIV_EN
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_DIV = 1'b1} state_t;

  state_t         state_q;
  state_t         state_d;
  state_t         dbg_state;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   quo_q;
  logic [W-1:0]   dsr_q;
  logic [CW-1:0]  cnt_q;
  logic [W:0]     rem_shift;
  logic           rem_ge;
  logic [W-1:0]   rem_nx;
  logic [W-1:0]   quo_nx;

  assign dbg_state = state_q;
  assign o_Ready   = (state_q == S_IDLE);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // When it fits the true difference is below the divisor, so W-bit
  // modular subtraction is exact.
  always_comb begin
    rem_shift = {rem_q, quo_q[W-1]};
    rem_ge    = (rem_shift >= {1'b0, dsr_q});
    rem_nx    = rem_ge ? (rem_shift[W-1:0] - dsr_q) : rem_shift[W-1:0];
    quo_nx    = {quo_q[W-2:0], rem_ge};
    div_res   = {rem_nx, quo_nx};
  end

  // Next-state logic; div_done marks the edge performing the last step.
  always_comb begin
    state_d  = state_q;
    div_done = 1'b0;
    case (state_q)
      S_IDLE: if (accept && start_div) state_d = S_DIV;
      S_DIV: begin
        if (cnt_q == CW'(W - 1)) begin
          div_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any division in flight.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Divider datapath: load operands on accept, iterate while in DIV.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (accept && start_div) begin
        rem_q <= '0;
        quo_q <= i_A;
        dsr_q <= i_B;
        cnt_q <= '0;
      end
    end else begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  assign o_Ready  = 1'b1;
  assign div_done = 1'b0;
  assign div_res  = '0;
`endif

  // Output registers: load on a single-cycle completion or the last DIV step.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      o_ALU_OUT   <= '0;
      o_OUT_Valid <= 1'b0;
      o_Zero      <= 1'b0;
      o_Carry     <= 1'b0;
      o_Err       <= 1'b0;
    end else begin
      o_OUT_Valid <= 1'b0;
      if (accept && !start_div) begin
        o_ALU_OUT   <= res_c;
        o_Zero      <= (res_c == '0);
        o_Carry     <= carry_c;
        o_Err       <= err_c;
        o_OUT_Valid <= 1'b1;
      end else if (div_done) begin
        o_ALU_OUT   <= div_res;
        o_Zero      <= (div_res == '0);
        o_Carry     <= 1'b0;
        o_Err       <= 1'b0;
        o_OUT_Valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_hs.sv
// Self-checking bench for alu_hs (W=8): directed vectors with hand-computed
// expectations pushed into a scoreboard queue; a monitor pops on o_OUT_Valid.
module tb_alu_hs;

  localparam int DW = 8;
  localparam int FW = 4;
  localparam int EW = 2*DW + 3;

`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic            i_CLK;
  logic            i_RST;
  logic [DW-1:0]   i_A;
  logic [DW-1:0]   i_B;
  logic [FW-1:0]   i_ALU_FUN;
  logic            i_Valid;
  logic            o_Ready;
  logic [2*DW-1:0] o_ALU_OUT;
  logic            o_OUT_Valid;
  logic            o_Zero;
  logic            o_Carry;
  logic            o_Err;

  int checks    = 0;
  int errors    = 0;
  int valid_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;

  alu_hs #(.DATA_WIDTH(DW), .ALU_FUN_WIDTH(FW)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_A(i_A), .i_B(i_B),
    .i_ALU_FUN(i_ALU_FUN), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .o_ALU_OUT(o_ALU_OUT), .o_OUT_Valid(o_OUT_Valid), .o_Zero(o_Zero),
    .o_Carry(o_Carry), .o_Err(o_Err)
  );

  // Clock and watchdog
  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid strobe must match the head of the expected queue.
  always @(negedge i_CLK) begin
    if (o_OUT_Valid === 1'b1) begin
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid: got res=%h z=%b c=%b e=%b, expected no result",
                 o_ALU_OUT, o_Zero, o_Carry, o_Err);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({o_ALU_OUT, o_Zero, o_Carry, o_Err} !== mon_exp) begin
          errors++;
          $display("FAIL result: got res=%h z=%b c=%b e=%b, expected res=%h z=%b c=%b e=%b",
                   o_ALU_OUT, o_Zero, o_Carry, o_Err,
                   mon_exp[EW-1:3], mon_exp[2], mon_exp[1], mon_exp[0]);
        end
      end
    end
  end

  // Driver: called at a negedge; holds the request until o_Ready, pushes the
  // expectation, returns at the negedge after the accepting edge.
  task automatic send(input logic [FW-1:0] op, input logic [DW-1:0] a,
                      input logic [DW-1:0] b, input logic [2*DW-1:0] res,
                      input logic z, input logic c, input logic e,
                      output int waits);
    i_ALU_FUN = op;
    i_A       = a;
    i_B       = b;
    i_Valid   = 1'b1;
    waits     = 0;
    while (o_Ready !== 1'b1 && waits < 100) begin
      @(negedge i_CLK);
      waits++;
    end
    if (waits >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got o_Ready=%b, expected 1", o_Ready);
    end else begin
      exp_q.push_back({res, z, c, e});
      @(negedge i_CLK);
    end
    i_Valid = 1'b0;
  endtask

  int w;
  int v0;

  initial begin
    i_RST = 1'b0; i_A = '0; i_B = '0; i_ALU_FUN = '0; i_Valid = 1'b0;
    repeat (2) @(negedge i_CLK);
    chk("rst_out",   o_ALU_OUT,   0);
    chk("rst_valid", o_OUT_Valid, 0);
    chk("rst_zero",  o_Zero,      0);
    chk("rst_carry", o_Carry,     0);
    chk("rst_err",   o_Err,       0);
    i_RST = 1'b1;
    @(negedge i_CLK);
    chk("ready_after_rst", o_Ready, 1);

    send(4'd0, 8'd200, 8'd100, 16'h012C, 0, 1, 0, w);
    send(4'd1, 8'd3,   8'd5,   16'hFFFE, 0, 1, 0, w);
    send(4'd2, 8'd255, 8'd255, 16'hFE01, 0, 1, 0, w);

    // DIV 200/7 followed by a held DIV-by-zero request
    if (DIV_EN) send(4'd3, 8'd200, 8'd7, 16'h041C, 0, 0, 0, w);
    else        send(4'd3, 8'd200, 8'd7, 16'h0000, 1, 0, 1, w);
    chk("div_accept_wait", w, 0);
    send(4'd3, 8'd5, 8'd0, 16'h0000, 1, 0, 1, w);
    chk("div_busy_cycles", w, DIV_EN ? 8 : 0);
    send(4'd0, 8'd1, 8'd1, 16'h0002, 0, 0, 0, w);

    // Back-to-back single-cycle ops
    @(negedge i_CLK);
    v0 = valid_cnt;
    send(4'd8,  8'hA5, 8'h0F, 16'h00AA, 0, 0, 0, w); chk("b2b_wait0", w, 0);
    send(4'd10, 8'd3,  8'd3,  16'h0001, 0, 0, 0, w); chk("b2b_wait1", w, 0);
    send(4'd14, 8'h01, 8'h00, 16'h0000, 1, 0, 0, w); chk("b2b_wait2", w, 0);
    send(4'd15, 8'h12, 8'h34, 16'h0000, 1, 0, 1, w); chk("b2b_wait3", w, 0);
    @(negedge i_CLK);
    chk("b2b_valid_count", valid_cnt - v0, 4);

    // Remaining opcodes
    send(4'd13, 8'h81, 8'h00, 16'h0102, 0, 1, 0, w);
    send(4'd7,  8'h0F, 8'hF0, 16'h0000, 1, 0, 0, w);
    send(4'd6,  8'hF0, 8'hF0, 16'h000F, 0, 0, 0, w);
    send(4'd12, 8'd2,  8'd9,  16'h0001, 0, 0, 0, w);
    send(4'd11, 8'd9,  8'd2,  16'h0001, 0, 0, 0, w);
    send(4'd9,  8'hA5, 8'h0F, 16'h0055, 0, 0, 0, w);
    send(4'd5,  8'h30, 8'h03, 16'h0033, 0, 0, 0, w);
    send(4'd4,  8'h3C, 8'h0F, 16'h000C, 0, 0, 0, w);

    // Reset during DIV step 3 of 200/7
    send(4'd0, 8'd200, 8'd100, 16'h012C, 0, 1, 0, w);
    i_ALU_FUN = 4'd3; i_A = 8'd200; i_B = 8'd7; i_Valid = 1'b1;
    if (!DIV_EN) exp_q.push_back({16'h0000, 1'b1, 1'b0, 1'b1});
    @(negedge i_CLK);
    i_Valid = 1'b0;
    repeat (3) @(negedge i_CLK);
    chk("ready_mid_div", o_Ready, DIV_EN ? 0 : 1);
    v0 = valid_cnt;
    i_RST = 1'b0;
    #1;
    chk("rst_div_out",   o_ALU_OUT,   0);
    chk("rst_div_valid", o_OUT_Valid, 0);
    chk("rst_div_flags", {o_Zero, o_Carry, o_Err}, 0);
    repeat (2) @(negedge i_CLK);
    i_RST = 1'b1;
    repeat (12) @(negedge i_CLK);
    chk("ready_after_abort", o_Ready, 1);
    chk("no_valid_after_abort", valid_cnt - v0, 0);

    repeat (4) @(negedge i_CLK);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
